// File: rtl/seg_shift_rx_if.sv
// Output side of the display shift-chain receiver: latched frame plus valid/ready buffer handshake.
interface seg_shift_rx_if #(
  parameter int unsigned FRAME_BITS = 64
);
  logic [FRAME_BITS-1:0] frame_data;
  logic [7:0]            frame_len;
  logic                  frame_len_err;
  logic                  frame_valid;
  logic                  frame_ready;
  logic                  overrun;

  modport master (
    output frame_data, frame_len, frame_len_err, frame_valid, overrun,
    input  frame_ready
  );

  modport slave (
    input  frame_data, frame_len, frame_len_err, frame_valid, overrun,
    output frame_ready
  );
endinterface

// File: rtl/seg_shift_rx.sv
// Oversampling receiver for the clk/pen/clr_n/do display shift chain with a one-deep frame buffer.
// Optional SEG_SHIFT_RX_GLITCH_FILTER_EN adds a 2-cycle qualifier on ser_clk/ser_pen edges.
module seg_shift_rx #(
  parameter int unsigned FRAME_BITS  = 64,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           rst_async_n,
  input  logic           ser_clk,
  input  logic           ser_do,
  input  logic           ser_pen,
  input  logic           ser_clr_n,
  seg_shift_rx_if.master out_if
);

  localparam int unsigned   CNT_W     = 8;
  localparam int unsigned   L_CLK     = 0;
  localparam int unsigned   L_DO      = 1;
  localparam int unsigned   L_PEN     = 2;
  localparam int unsigned   L_CLR     = 3;
  localparam logic [CNT_W-1:0] CNT_MAX   = 8'hFF;
  localparam logic [CNT_W-1:0] FRAME_LEN = CNT_W'(FRAME_BITS);

  typedef enum logic {S_IDLE, S_SHIFT} state_e;

  logic [3:0]                    pins_c;
  logic [SYNC_STAGES-1:0][3:0]   sync_q, sync_d;
  logic [3:0]                    sync_last_c;
  logic [1:0]                    edge_lvl_c;
  logic [1:0]                    rise_c;
  logic                          do_use_c;

  state_e                  state_q, state_d;
  logic [FRAME_BITS-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [FRAME_BITS-1:0]   frame_data_q, frame_data_d;
  logic [CNT_W-1:0]        frame_len_q, frame_len_d;
  logic                    frame_len_err_q, frame_len_err_d;
  logic                    frame_valid_q, frame_valid_d;
  logic                    overrun_q, overrun_d;

  assign pins_c      = {ser_clr_n, ser_pen, ser_do, ser_clk};
  assign sync_last_c = sync_q[SYNC_STAGES-1];
  assign edge_lvl_c  = {sync_last_c[L_PEN], sync_last_c[L_CLK]};

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pins_c};
  end

`ifdef SEG_SHIFT_RX_GLITCH_FILTER_EN
  // Accepted level follows the synced level only after it has differed for two cycles.
  logic [1:0] acc_q, acc_d, pend_q, pend_d;
  logic [1:0] accept_c;
  logic       do_dly_q, do_dly_d;

  always_comb begin
    accept_c = (edge_lvl_c ^ acc_q) & pend_q;
    acc_d    = acc_q ^ accept_c;
    pend_d   = (edge_lvl_c ^ acc_q) & ~accept_c;
    rise_c   = accept_c & edge_lvl_c;
    do_dly_d = sync_last_c[L_DO];
    do_use_c = do_dly_q;
  end

  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      acc_q    <= '0;
      pend_q   <= '0;
      do_dly_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      pend_q   <= pend_d;
      do_dly_q <= do_dly_d;
    end
  end
`else
  logic [1:0] dly_q, dly_d;

  always_comb begin
    dly_d    = edge_lvl_c;
    rise_c   = edge_lvl_c & ~dly_q;
    do_use_c = sync_last_c[L_DO];
  end

  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) dly_q <= '0;
    else              dly_q <= dly_d;
  end
`endif

  // Capture FSM, latch into the output buffer, and consumer handshake.
  always_comb begin
    state_d         = state_q;
    shreg_d         = shreg_q;
    cnt_d           = cnt_q;
    frame_data_d    = frame_data_q;
    frame_len_d     = frame_len_q;
    frame_len_err_d = frame_len_err_q;
    frame_valid_d   = frame_valid_q & ~out_if.frame_ready;
    overrun_d       = overrun_q;

    if (!sync_last_c[L_CLR]) begin
      state_d = S_IDLE;
      shreg_d = '0;
      cnt_d   = '0;
    end else begin
      if (rise_c[0]) begin
        shreg_d = {shreg_q[FRAME_BITS-2:0], do_use_c};
        cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        state_d = S_SHIFT;
      end
      // A shift in the same cycle as the strobe is already folded into shreg_d/cnt_d.
      if (rise_c[1] && (state_d == S_SHIFT)) begin
        if (!frame_valid_q || out_if.frame_ready) begin
          frame_data_d    = shreg_d;
          frame_len_d     = cnt_d;
          frame_len_err_d = (cnt_d != FRAME_LEN);
          frame_valid_d   = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
        shreg_d = '0;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      sync_q          <= '0;
      state_q         <= S_IDLE;
      shreg_q         <= '0;
      cnt_q           <= '0;
      frame_data_q    <= '0;
      frame_len_q     <= '0;
      frame_len_err_q <= 1'b0;
      frame_valid_q   <= 1'b0;
      overrun_q       <= 1'b0;
    end else begin
      sync_q          <= sync_d;
      state_q         <= state_d;
      shreg_q         <= shreg_d;
      cnt_q           <= cnt_d;
      frame_data_q    <= frame_data_d;
      frame_len_q     <= frame_len_d;
      frame_len_err_q <= frame_len_err_d;
      frame_valid_q   <= frame_valid_d;
      overrun_q       <= overrun_d;
    end
  end

  assign out_if.frame_data    = frame_data_q;
  assign out_if.frame_len     = frame_len_q;
  assign out_if.frame_len_err = frame_len_err_q;
  assign out_if.frame_valid   = frame_valid_q;
  assign out_if.overrun       = overrun_q;

endmodule

// File: tb/tb_seg_shift_rx.sv
// Randomized bench for seg_shift_rx; the model keeps every shifted bit in a queue and
// derives each frame as "the last FRAME_BITS bits, newest at the LSB".
module tb_seg_shift_rx;
  localparam int FB   = 64;
  localparam int SS   = 2;
  localparam int HOLD = SS + 2;
`ifdef SEG_SHIFT_RX_GLITCH_FILTER_EN
  localparam int LAT  = SS + 1;
`else
  localparam int LAT  = SS;
`endif

  logic clk = 1'b0;
  logic rst_async_n = 1'b0;
  logic ser_clk = 1'b0;
  logic ser_do = 1'b0;
  logic ser_pen = 1'b0;
  logic ser_clr_n = 1'b1;

  seg_shift_rx_if #(.FRAME_BITS(FB)) rx_if ();

  seg_shift_rx #(.FRAME_BITS(FB), .SYNC_STAGES(SS)) dut (
    .clk        (clk),
    .rst_async_n(rst_async_n),
    .ser_clk    (ser_clk),
    .ser_do     (ser_do),
    .ser_pen    (ser_pen),
    .ser_clr_n  (ser_clr_n),
    .out_if     (rx_if.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  bit          mbits[$];
  int          mcnt = 0;
  logic          exp_valid = 1'b0;
  logic [FB-1:0] exp_data = '0;
  logic [7:0]    exp_len = '0;
  logic          exp_err = 1'b0;
  logic          exp_ovr = 1'b0;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [FB-1:0] model_frame();
    logic [FB-1:0] f = '0;
    int sz = mbits.size();
    for (int k = 0; k < FB && k < sz; k++) f[k] = mbits[sz-1-k];
    return f;
  endfunction

  // Called in the timestep ser_pen was raised; updates the model and checks latency and outputs.
  task automatic latch_wait();
    bit load      = (mcnt > 0) && (!exp_valid || rx_if.frame_ready);
    bit was_valid = exp_valid;
    if (mcnt > 0) begin
      if (load) begin
        exp_data  = model_frame();
        exp_len   = (mcnt > 255) ? 8'd255 : 8'(mcnt);
        exp_err   = (exp_len != 8'(FB));
        exp_valid = 1'b1;
      end else begin
        exp_ovr = 1'b1;
      end
    end
    mbits.delete();
    mcnt = 0;
    step(LAT);
    if (!was_valid) begin
      checks++;
      if (rx_if.frame_valid !== 1'b0) begin
        errors++;
        $display("FAIL latch_early valid got %b exp 0", rx_if.frame_valid);
      end
    end
    step(1);
    checks++;
    if (rx_if.frame_valid !== exp_valid) begin
      errors++;
      $display("FAIL latch_valid got %b exp %b", rx_if.frame_valid, exp_valid);
    end
    checks++;
    if (rx_if.frame_data !== exp_data) begin
      errors++;
      $display("FAIL latch_data got %h exp %h", rx_if.frame_data, exp_data);
    end
    checks++;
    if (rx_if.frame_len !== exp_len) begin
      errors++;
      $display("FAIL latch_len got %0d exp %0d", rx_if.frame_len, exp_len);
    end
    checks++;
    if (rx_if.frame_len_err !== exp_err) begin
      errors++;
      $display("FAIL latch_len_err got %b exp %b", rx_if.frame_len_err, exp_err);
    end
    checks++;
    if (rx_if.overrun !== exp_ovr) begin
      errors++;
      $display("FAIL latch_overrun got %b exp %b", rx_if.overrun, exp_ovr);
    end
    if (rx_if.frame_ready) begin
      step(1);
      exp_valid = 1'b0;
      checks++;
      if (rx_if.frame_valid !== 1'b0) begin
        errors++;
        $display("FAIL drain_after_latch valid got %b exp 0", rx_if.frame_valid);
      end
    end
  endtask

  task automatic drive_bit(input bit b, input bit with_pen, input bit glitch);
    ser_do = b;
    step(HOLD);
    if (glitch) begin
      ser_clk = 1'b1;
      step(1);
      ser_clk = 1'b0;
      step(HOLD);
    end
    ser_clk = 1'b1;
    if (with_pen) ser_pen = 1'b1;
    mbits.push_back(b);
    mcnt++;
    if (with_pen) latch_wait();
    else          step(HOLD);
    ser_clk = 1'b0;
    step(HOLD);
    if (with_pen) begin
      ser_pen = 1'b0;
      step(HOLD);
    end
  endtask

  task automatic send_pen();
    ser_pen = 1'b1;
    latch_wait();
    step(HOLD);
    ser_pen = 1'b0;
    step(HOLD);
  endtask

  task automatic send_word(input logic [FB-1:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) drive_bit(w[i], 1'b0, 1'b0);
  endtask

  task automatic send_random(input int n, input bit glitch);
    for (int i = 0; i < n; i++) drive_bit(1'($urandom_range(0, 1)), 1'b0, glitch);
  endtask

  task automatic test_drain();
    checks++;
    if (rx_if.frame_valid !== exp_valid) begin
      errors++;
      $display("FAIL drain_pre valid got %b exp %b", rx_if.frame_valid, exp_valid);
    end
    rx_if.frame_ready = 1'b1;
    step(1);
    exp_valid = 1'b0;
    checks++;
    if (rx_if.frame_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_post valid got %b exp 0", rx_if.frame_valid);
    end
    checks++;
    if (rx_if.overrun !== exp_ovr) begin
      errors++;
      $display("FAIL drain_overrun got %b exp %b", rx_if.overrun, exp_ovr);
    end
  endtask

  task automatic test_reset();
    step(3);
    checks++;
    if ({rx_if.frame_valid, rx_if.frame_len_err, rx_if.overrun} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags got %b exp 000",
               {rx_if.frame_valid, rx_if.frame_len_err, rx_if.overrun});
    end
    checks++;
    if (rx_if.frame_data !== '0 || rx_if.frame_len !== 8'd0) begin
      errors++;
      $display("FAIL reset_data got %h/%0d exp 0/0", rx_if.frame_data, rx_if.frame_len);
    end
    rst_async_n = 1'b1;
    step(HOLD);
  endtask

  task automatic test_full_frame();
    rx_if.frame_ready = 1'b1;
    send_word(64'hA5A5_0000_FFFF_1234, 64);
    send_pen();
  endtask

  task automatic test_short_long();
    rx_if.frame_ready = 1'b1;
    send_word(FB'(10'b1011001110), 10);
    send_pen();
    send_random(70, 1'b0);
    send_pen();
  endtask

  task automatic test_overrun();
    rx_if.frame_ready = 1'b0;
    send_random($urandom_range(5, 64), 1'b0);
    send_pen();
    send_random($urandom_range(5, 64), 1'b0);
    send_pen();
    test_drain();
  endtask

  task automatic test_clear();
    rx_if.frame_ready = 1'b1;
    send_random(20, 1'b0);
    ser_clr_n = 1'b0;
    step(HOLD);
    ser_clk = 1'b1;
    step(HOLD);
    ser_clk = 1'b0;
    ser_pen = 1'b1;
    step(HOLD);
    ser_pen = 1'b0;
    step(HOLD);
    ser_clr_n = 1'b1;
    step(HOLD);
    mbits.delete();
    mcnt = 0;
    checks++;
    if (rx_if.frame_valid !== 1'b0) begin
      errors++;
      $display("FAIL clear_no_frame valid got %b exp 0", rx_if.frame_valid);
    end
    send_word({FB{1'b1}}, FB);
    send_pen();
    send_pen();
  endtask

  task automatic test_simultaneous();
    rx_if.frame_ready = 1'b1;
    send_random(FB - 1, 1'b0);
    drive_bit(1'($urandom_range(0, 1)), 1'b1, 1'b0);
  endtask

  task automatic test_reset_midframe();
    rx_if.frame_ready = 1'b0;
    send_random(8, 1'b0);
    send_pen();
    send_random(5, 1'b0);
    rst_async_n = 1'b0;
    #1;
    checks++;
    if ({rx_if.frame_valid, rx_if.frame_len_err, rx_if.overrun} !== 3'b000) begin
      errors++;
      $display("FAIL midreset_flags got %b exp 000",
               {rx_if.frame_valid, rx_if.frame_len_err, rx_if.overrun});
    end
    checks++;
    if (rx_if.frame_data !== '0 || rx_if.frame_len !== 8'd0) begin
      errors++;
      $display("FAIL midreset_data got %h/%0d exp 0/0", rx_if.frame_data, rx_if.frame_len);
    end
    step(2);
    rst_async_n = 1'b1;
    mbits.delete();
    mcnt = 0;
    exp_valid = 1'b0;
    exp_data  = '0;
    exp_len   = '0;
    exp_err   = 1'b0;
    exp_ovr   = 1'b0;
    step(HOLD);
    rx_if.frame_ready = 1'b1;
    send_random(12, 1'b0);
    send_pen();
  endtask

  task automatic test_random();
    for (int f = 0; f < 6; f++) begin
      bit r = 1'($urandom_range(0, 1));
      if (r && exp_valid) test_drain();
      rx_if.frame_ready = r;
      send_random($urandom_range(1, 90), 1'b0);
      send_pen();
    end
  endtask

`ifdef SEG_SHIFT_RX_GLITCH_FILTER_EN
  task automatic test_glitch();
    if (exp_valid) test_drain();
    rx_if.frame_ready = 1'b1;
    send_random(FB, 1'b1);
    send_pen();
  endtask
`endif

  initial begin
    rx_if.frame_ready = 1'b0;
    test_reset();
    test_full_frame();
    test_short_long();
    test_overrun();
    test_clear();
    test_simultaneous();
    test_reset_midframe();
    test_random();
`ifdef SEG_SHIFT_RX_GLITCH_FILTER_EN
    test_glitch();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog timeout got running exp finished");
    $fatal(1, "watchdog");
  end

endmodule
